// File: rtl/frame_stream_tx_if.sv
// Pixel-stream transmitter bus: start/loop control, RAM read port, raster output and status.
// master is the transmitter's view; slave is the view of the controller, RAM and pipeline.
interface frame_stream_tx_if #(
  parameter int ADDR_WIDTH = 20,
  parameter int PIXEL_SIZE = 24
);
  logic                  start;
  logic                  loop;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [PIXEL_SIZE-1:0] rd_data;
  logic                  en;
  logic [PIXEL_SIZE-1:0] data;
  logic                  hsync;
  logic                  vsync;
  logic                  busy;
  logic                  done;
  logic [15:0]           frame_count;

  modport master (
    input  start, loop, rd_data,
    output rd_en, rd_addr, en, data, hsync, vsync, busy, done, frame_count
  );

  modport slave (
    output start, loop, rd_data,
    input  rd_en, rd_addr, en, data, hsync, vsync, busy, done, frame_count
  );
endinterface

// File: rtl/frame_stream_tx.sv
// Frame-buffer raster transmitter: S0 walks the frame and reads RAM, S1 delays flags to meet rd_data.
// Start-to-first-pixel latency 2 cycles; start is ignored while busy and never queued.
module frame_stream_tx #(
  parameter int FRAME_WIDTH  = 550,
  parameter int FRAME_HEIGHT = 1,
  parameter int H_BLANK      = 1,
  parameter int V_BLANK      = 1,
  parameter int ADDR_WIDTH   = 20,
  parameter int PIXEL_SIZE   = 24
) (
  input  logic                   clk,
  input  logic                   reset_n,
  frame_stream_tx_if.master      bus
);

  localparam int XW   = $clog2(FRAME_WIDTH + 1);
  localparam int YW   = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
  localparam int BMAX = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
  localparam int BW   = $clog2(BMAX + 1);

  localparam logic [XW-1:0]         X_LAST  = XW'(FRAME_WIDTH - 1);
  localparam logic [YW-1:0]         Y_LAST  = YW'(FRAME_HEIGHT - 1);
  localparam logic [BW-1:0]         HB_LAST = BW'(H_BLANK - 1);
  localparam logic [BW-1:0]         VB_LAST = BW'(V_BLANK - 1);
  localparam logic [ADDR_WIDTH-1:0] A_LAST  = ADDR_WIDTH'(FRAME_WIDTH * FRAME_HEIGHT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HBLANK = 2'd2,
    VBLANK = 2'd3
  } state_t;

  // S0 state
  state_t                state_q, state_d;
  logic [XW-1:0]         x_q, x_d;
  logic [YW-1:0]         y_q, y_d;
  logic [BW-1:0]         b_q, b_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           fc_q, fc_d;

  // S1 state
  logic en_q, en_d;
  logic hsync_q, hsync_d;
  logic vsync_q, vsync_d;
  logic done_q, done_d;
  logic busy1_q, busy1_d;

  logic s0_en;
  logic s0_hsync;
  logic s0_vsync;
  logic s0_done;
  logic s0_busy;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      b_q     <= '0;
      addr_q  <= '0;
      fc_q    <= '0;
      en_q    <= 1'b0;
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
      done_q  <= 1'b0;
      busy1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      b_q     <= b_d;
      addr_q  <= addr_d;
      fc_q    <= fc_d;
      en_q    <= en_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      done_q  <= done_d;
      busy1_q <= busy1_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    b_d      = b_q;
    addr_d   = addr_q;
    s0_en    = 1'b0;
    s0_hsync = 1'b0;
    s0_vsync = 1'b0;
    s0_done  = 1'b0;

    case (state_q)
      IDLE: begin
        // S1 may still be emitting the done cycle; a start then must not be accepted.
        if (bus.start && !busy1_q) begin
          state_d = ACTIVE;
          x_d     = '0;
          y_d     = '0;
          b_d     = '0;
          addr_d  = '0;
        end
      end
      ACTIVE: begin
        s0_en  = 1'b1;
        addr_d = (addr_q == A_LAST) ? '0 : addr_q + 1'b1;
        if (x_q == X_LAST) begin
          x_d     = '0;
          b_d     = '0;
          state_d = (y_q == Y_LAST) ? VBLANK : HBLANK;
        end else begin
          x_d = x_q + 1'b1;
        end
      end
      HBLANK: begin
        s0_hsync = (b_q == '0);
        if (b_q == HB_LAST) begin
          b_d     = '0;
          y_d     = y_q + 1'b1;
          state_d = ACTIVE;
        end else begin
          b_d = b_q + 1'b1;
        end
      end
      VBLANK: begin
        s0_vsync = (b_q == '0);
        if (b_q == VB_LAST) begin
          b_d = '0;
          x_d = '0;
          y_d = '0;
          // loop is only looked at here, so dropping it mid-frame finishes the frame.
          if (bus.loop) begin
            addr_d  = '0;
            state_d = ACTIVE;
          end else begin
            s0_done = 1'b1;
            state_d = IDLE;
          end
        end else begin
          b_d = b_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s0_busy = (state_q != IDLE);
    en_d    = s0_en;
    hsync_d = s0_hsync;
    vsync_d = s0_vsync;
    done_d  = s0_done;
    busy1_d = s0_busy;
    // Counter lands on the same cycle the delayed vsync reaches the output.
    fc_d    = fc_q + {15'd0, s0_vsync};
  end

  assign bus.rd_en       = s0_en;
  assign bus.rd_addr     = addr_q;
  assign bus.en          = en_q;
  assign bus.data        = en_q ? bus.rd_data : '0;
  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.done        = done_q;
  assign bus.busy        = s0_busy | busy1_q;
  assign bus.frame_count = fc_q;

endmodule

// File: tb/tb_frame_stream_tx.sv
// Directed bench for frame_stream_tx: a W4/H2 instance and a degenerate W3/H1 instance, RAM holds i+1.
module tb_frame_stream_tx;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  frame_stream_tx_if #(.ADDR_WIDTH(8), .PIXEL_SIZE(24)) bus0 ();
  frame_stream_tx_if #(.ADDR_WIDTH(4), .PIXEL_SIZE(24)) bus1 ();

  frame_stream_tx #(
    .FRAME_WIDTH(4), .FRAME_HEIGHT(2), .H_BLANK(2), .V_BLANK(3),
    .ADDR_WIDTH(8), .PIXEL_SIZE(24)
  ) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0.master)
  );

  frame_stream_tx #(
    .FRAME_WIDTH(3), .FRAME_HEIGHT(1), .H_BLANK(1), .V_BLANK(1),
    .ADDR_WIDTH(4), .PIXEL_SIZE(24)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read RAM models, mem[i] = i+1.
  always @(posedge clk) if (bus0.rd_en) bus0.rd_data <= 24'(bus0.rd_addr) + 24'd1;
  always @(posedge clk) if (bus1.rd_en) bus1.rd_data <= 24'(bus1.rd_addr) + 24'd1;

  // Expected output words: {busy, done, vsync, hsync, en, 3'b0, data[23:0]}
  localparam logic [31:0] EXP_A [0:16] = '{
    32'h0000_0000, 32'h8000_0000,
    32'h8800_0001, 32'h8800_0002, 32'h8800_0003, 32'h8800_0004,
    32'h9000_0000, 32'h8000_0000,
    32'h8800_0005, 32'h8800_0006, 32'h8800_0007, 32'h8800_0008,
    32'hA000_0000, 32'h8000_0000, 32'hC000_0000,
    32'h0000_0000, 32'h0000_0000
  };

  localparam logic [31:0] EXP_E [0:8] = '{
    32'h0000_0000, 32'h8000_0000,
    32'h8800_0001, 32'h8800_0002, 32'h8800_0003,
    32'hE000_0000, 32'h0000_0000,
    32'h8000_0000, 32'h8800_0001
  };

  function automatic logic [31:0] obs0();
    return {bus0.busy, bus0.done, bus0.vsync, bus0.hsync, bus0.en, 3'b000, bus0.data};
  endfunction

  function automatic logic [31:0] obs1();
    return {bus1.busy, bus1.done, bus1.vsync, bus1.hsync, bus1.en, 3'b000, bus1.data};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_seq();
    bus0.start = 1'b0;
    bus0.loop  = 1'b0;
    bus1.start = 1'b0;
    bus1.loop  = 1'b0;
    reset_n    = 1'b0;
    tick();
    tick();
    reset_n    = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;

    // Single frame, loop low.
    reset_seq();
    check_val("rst_out", obs0(), 32'h0);
    check_val("rst_rd", {23'd0, bus0.rd_en, bus0.rd_addr}, 32'h0);
    check_val("rst_fc", {16'd0, bus0.frame_count}, 32'h0);
    for (int c = 0; c <= 16; c++) begin
      bus0.start = (c == 0);
      check_val($sformatf("A_c%0d", c), obs0(), EXP_A[c]);
      if (c == 1)  check_val("A_rd_c1",  {23'd0, bus0.rd_en, bus0.rd_addr}, 32'h100);
      if (c == 4)  check_val("A_rd_c4",  {23'd0, bus0.rd_en, bus0.rd_addr}, 32'h103);
      if (c == 5)  check_val("A_rd_c5",  {31'd0, bus0.rd_en}, 32'h0);
      if (c == 7)  check_val("A_rd_c7",  {23'd0, bus0.rd_en, bus0.rd_addr}, 32'h104);
      if (c == 10) check_val("A_rd_c10", {23'd0, bus0.rd_en, bus0.rd_addr}, 32'h107);
      if (c == 12) check_val("A_rd_c12", {23'd0, bus0.rd_en, bus0.rd_addr}, 32'h000);
      if (c == 11) check_val("A_fc_c11", {16'd0, bus0.frame_count}, 32'd0);
      if (c == 12) check_val("A_fc_c12", {16'd0, bus0.frame_count}, 32'd1);
      tick();
    end

    // Loop high, dropped at cycle 20.
    reset_seq();
    for (int c = 0; c <= 29; c++) begin
      bus0.start = (c == 0);
      bus0.loop  = (c < 20);
      case (c)
        12: begin
          check_val("B_vs1", obs0(), 32'hA000_0000);
          check_val("B_fc1", {16'd0, bus0.frame_count}, 32'd1);
        end
        14: check_val("B_nodone", obs0(), 32'h8000_0000);
        15: check_val("B_px1", obs0(), 32'h8800_0001);
        16: check_val("B_px2", obs0(), 32'h8800_0002);
        19: check_val("B_hs2", obs0(), 32'h9000_0000);
        25: begin
          check_val("B_vs2", obs0(), 32'hA000_0000);
          check_val("B_fc2", {16'd0, bus0.frame_count}, 32'd2);
        end
        26: check_val("B_blank", obs0(), 32'h8000_0000);
        27: check_val("B_done", obs0(), 32'hC000_0000);
        28: check_val("B_idle", obs0(), 32'h0000_0000);
        default: ;
      endcase
      tick();
    end

    // start held high: no restart while busy, re-accepted the cycle after done.
    reset_seq();
    for (int c = 0; c <= 17; c++) begin
      bus0.start = 1'b1;
      case (c)
        1:  check_val("C_rd_c1", {23'd0, bus0.rd_en, bus0.rd_addr}, 32'h100);
        3:  check_val("C_rd_c3", {23'd0, bus0.rd_en, bus0.rd_addr}, 32'h102);
        5:  check_val("C_px4", obs0(), 32'h8800_0004);
        8:  check_val("C_px5", obs0(), 32'h8800_0005);
        14: check_val("C_done", obs0(), 32'hC000_0000);
        15: begin
          check_val("C_free", obs0(), 32'h0000_0000);
          check_val("C_rd_c15", {31'd0, bus0.rd_en}, 32'h0);
        end
        16: begin
          check_val("C_busy2", obs0(), 32'h8000_0000);
          check_val("C_rd_c16", {23'd0, bus0.rd_en, bus0.rd_addr}, 32'h100);
        end
        17: check_val("C_px1b", obs0(), 32'h8800_0001);
        default: ;
      endcase
      tick();
    end

    // Reset in the middle of row 1, then restart.
    reset_seq();
    for (int c = 0; c <= 14; c++) begin
      bus0.start = (c == 0) || (c == 11);
      reset_n    = (c != 9);
      case (c)
        8:  check_val("D_px5", obs0(), 32'h8800_0005);
        10: begin
          check_val("D_rst_out", obs0(), 32'h0);
          check_val("D_rst_rd", {23'd0, bus0.rd_en, bus0.rd_addr}, 32'h0);
          check_val("D_rst_fc", {16'd0, bus0.frame_count}, 32'h0);
        end
        11: check_val("D_idle", obs0(), 32'h0);
        12: check_val("D_busy", obs0(), 32'h8000_0000);
        13: check_val("D_px1", obs0(), 32'h8800_0001);
        14: check_val("D_px2", obs0(), 32'h8800_0002);
        default: ;
      endcase
      tick();
    end

    // Degenerate W3/H1/V_BLANK1 instance, two back-to-back runs.
    reset_seq();
    for (int c = 0; c <= 8; c++) begin
      bus1.start = (c == 0) || (c == 6);
      check_val($sformatf("E_c%0d", c), obs1(), EXP_E[c]);
      if (c == 3) check_val("E_rd_c3", {27'd0, bus1.rd_en, bus1.rd_addr}, 32'h12);
      if (c == 4) check_val("E_rd_c4", {27'd0, bus1.rd_en, bus1.rd_addr}, 32'h00);
      if (c == 7) check_val("E_rd_c7", {27'd0, bus1.rd_en, bus1.rd_addr}, 32'h10);
      if (c == 5) check_val("E_fc_c5", {16'd0, bus1.frame_count}, 32'd1);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
